// File: rtl/mem_wb_stage_if.sv
// Memory-side bus between the MEM stage and the data memory.
// Request/strobe/address/data go out; read data and a one-cycle ready pulse come back.
// No clock inside: both ends sample on the stage clock.
interface mem_wb_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  // The pipeline stage issues requests.
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  // The memory answers them.
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register; optional MEM_ALIGN_CHECK_EN adds misaligned-access trapping.
// Latency: ALU op 1 cycle to WB outputs; memory op N+2 cycles (N = ACCESS cycles incl. the ready cycle).
// Backpressure: Freeze stalls all upstream stages from the first cycle of a memory op until its data returns.
module mem_wb_stage (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WB_EN_In,
  input  logic                  MEM_R_EN,
  input  logic                  MEM_W_EN,
  input  logic [31:0]           ALU_Res,
  input  logic [31:0]           Val_Rm,
  input  logic [3:0]            DestIn,
  mem_wb_stage_if.master        mem,
  output logic                  Freeze,
  output logic [3:0]            MEM_Dest,
  output logic                  MEM_WB_EN,
  output logic [3:0]            WB_Dest,
  output logic [31:0]           WB_Value,
  output logic                  WB_WB_EN,
  output logic                  align_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] ld_buf_q, ld_buf_d;     // data captured on the ready pulse
  logic        wb_en_q, wb_en_d;
  logic        mem_r_en_q, mem_r_en_d;
  logic [3:0]  dest_q, dest_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [31:0] wb_ld_q, wb_ld_d;       // load data field of MEM/WB

  logic        mem_op;
  logic        misalign;
  logic        stall;
  logic [29:0] word_addr;

  assign mem_op = MEM_R_EN | MEM_W_EN;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = mem_op & (ALU_Res[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Data memory is mapped at byte 1024; 1024 has zero low bits, so subtracting
  // 256 from the word part gives the same word index without a borrow into [1:0].
  assign word_addr = ALU_Res[31:2] - 30'd256;

  // Upstream must hold while an access is being started or is in flight.
  assign stall = ((state_q == ST_IDLE) & mem_op & ~misalign) | (state_q == ST_ACCESS);

  // Outputs to memory and upstream; everything quiet while in reset.
  always_comb begin
    mem.mem_req   = ~rst & (state_q == ST_ACCESS);
    mem.mem_we    = ~rst & (state_q == ST_ACCESS) & MEM_W_EN & ~MEM_R_EN;
    mem.mem_addr  = {2'b00, word_addr};
    mem.mem_wdata = Val_Rm;
    Freeze        = ~rst & stall;
    align_err     = ~rst & (state_q == ST_IDLE) & misalign;
    MEM_Dest      = DestIn;
    MEM_WB_EN     = WB_EN_In;
    WB_Dest       = dest_q;
    WB_WB_EN      = wb_en_q;
    WB_Value      = mem_r_en_q ? wb_ld_q : alu_res_q;
  end

  // Next-state, load capture and MEM/WB register contents (bubble while stalled).
  always_comb begin
    state_d    = state_q;
    ld_buf_d   = ld_buf_q;
    wb_en_d    = 1'b0;
    mem_r_en_d = 1'b0;
    dest_d     = 4'd0;
    alu_res_d  = 32'd0;
    wb_ld_d    = wb_ld_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_op && !misalign) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (mem.mem_ready) begin
          ld_buf_d = mem.mem_rdata;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Retire: a plain ALU op from IDLE, or the memory op in DONE.
    if ((state_q == ST_DONE) || ((state_q == ST_IDLE) && !mem_op)) begin
      wb_en_d    = WB_EN_In;
      mem_r_en_d = MEM_R_EN;
      dest_d     = DestIn;
      alu_res_d  = ALU_Res;
    end
    if (state_q == ST_DONE) wb_ld_d = ld_buf_q;
  end

  // State and pipeline register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ld_buf_q   <= 32'd0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      dest_q     <= 4'd0;
      alu_res_q  <= 32'd0;
      wb_ld_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      ld_buf_q   <= ld_buf_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      dest_q     <= dest_d;
      alu_res_q  <= alu_res_d;
      wb_ld_q    <= wb_ld_d;
    end
  end

endmodule
